// File: rtl/vectadd_pio_edge_in.sv
// vectadd_pio_edge_in: Avalon-MM parallel input port with per-bit edge capture.
//   Synchronises an asynchronous input bus, exposes it as a read-only data
//   register, and latches selected edges into sticky capture bits that can
//   raise a level interrupt through a per-bit mask.
//
// Register map (word address):
//   0 data (RO)  1 reserved (reads 0)  2 irq_mask (RW)  3 edge_capture (RO, write clears)
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   address     slave word address
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data, bits [DATA_WIDTH-1:0] used
//   in_port     asynchronous external input bits
//   readdata    registered read data, 1-cycle latency, zero-extended
//   irq         level interrupt, |(edge_capture & irq_mask)
//
// Build option:
//   VECTADD_PIO_BIT_CLEAR_EN  defined: writes to address 3 clear only the bits
//                             set in writedata (write-1-to-clear).
//                             undefined: any write to address 3 clears all bits.
module vectadd_pio_edge_in #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  // Edge detection stays off until the chain and prev hold post-reset samples.
  localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] data_c;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] irq_mask_q;
  logic [DATA_WIDTH-1:0] edge_capture_q;
  logic [DATA_WIDTH-1:0] edge_capture_d;
  logic [DATA_WIDTH-1:0] edge_det_c;
  logic [DATA_WIDTH-1:0] clear_mask_c;
  logic [WARM_W-1:0]     warm_q;
  logic                  warm_done_c;
  logic                  wr_en_c;
  logic [31:0]           rd_d;
  logic                  unused_wdata;

  assign data_c       = sync_q[SYNC_STAGES-1];
  assign warm_done_c  = (warm_q == WARM_W'(WARM_CYCLES));
  assign wr_en_c      = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Per-bit edge detect between the chain output and its previous value.
  always_comb begin
    edge_det_c = '0;
    if (EDGE_TYPE == 0) begin
      edge_det_c = data_c & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det_c = ~data_c & prev_q;
    end else begin
      edge_det_c = data_c ^ prev_q;
    end
    if (!warm_done_c) begin
      edge_det_c = '0;
    end
  end

  // Capture clear from a write to address 3; a new edge on the same bit wins.
  always_comb begin
    clear_mask_c = '0;
    if (wr_en_c && (address == 2'd3)) begin
`ifdef VECTADD_PIO_BIT_CLEAR_EN
      clear_mask_c = writedata[DATA_WIDTH-1:0];
`else
      clear_mask_c = '1;
`endif
    end
    edge_capture_d = (edge_capture_q & ~clear_mask_c) | edge_det_c;
  end

  // Read mux, loaded into readdata every clock regardless of chipselect.
  always_comb begin
    rd_d = '0;
    case (address)
      2'd0:    rd_d = 32'(data_c);
      2'd2:    rd_d = 32'(irq_mask_q);
      2'd3:    rd_d = 32'(edge_capture_q);
      default: rd_d = '0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q         <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata       <= '0;
      warm_q         <= '0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q         <= data_c;
      edge_capture_q <= edge_capture_d;
      readdata       <= rd_d;
      if (wr_en_c && (address == 2'd2)) begin
        irq_mask_q <= writedata[DATA_WIDTH-1:0];
      end
      if (!warm_done_c) begin
        warm_q <= warm_q + WARM_W'(1);
      end
    end
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_vectadd_pio_edge_in.sv
// Self-checking bench for vectadd_pio_edge_in (DATA_WIDTH=8, SYNC_STAGES=2).
// dut drives EDGE_TYPE=0 (rising); dut2 shares the bus and uses EDGE_TYPE=2.
module tb_vectadd_pio_edge_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [7:0]  in_port2;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic        irq;
  logic        irq2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

`ifdef VECTADD_PIO_BIT_CLEAR_EN
  localparam logic [31:0] EXP_EC_PARTIAL = 32'h0000_0002;
  localparam logic        EXP_IRQ_UNMASK = 1'b1;
`else
  localparam logic [31:0] EXP_EC_PARTIAL = 32'h0000_0000;
  localparam logic        EXP_IRQ_UNMASK = 1'b0;
`endif

  vectadd_pio_edge_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  vectadd_pio_edge_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Scoreboard read: expected value queued at the request, popped at the response.
  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    address = a;
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    check(name, readdata, e);
  endtask

  typedef struct {
    logic [7:0] pin;
    logic [7:0] mask;
    logic [7:0] ec;
    logic       irq;
  } vec_t;

  vec_t vecs [5];

  initial begin
    // Each entry follows the previous one's in_port (first starts from 00).
    vecs[0] = '{pin: 8'hA5, mask: 8'h00, ec: 8'hA5, irq: 1'b0};
    vecs[1] = '{pin: 8'h5A, mask: 8'h0F, ec: 8'h5A, irq: 1'b1};
    vecs[2] = '{pin: 8'hFF, mask: 8'hA0, ec: 8'hA5, irq: 1'b1};
    vecs[3] = '{pin: 8'h00, mask: 8'hFF, ec: 8'h00, irq: 1'b0};
    vecs[4] = '{pin: 8'h3C, mask: 8'hC3, ec: 8'h3C, irq: 1'b0};

    reset      = 1'b1;
    address    = 2'd3;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;
    in_port2   = 8'h80;
    ticks(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata2", readdata2, 32'h0);
    check("reset_irq2", 32'(irq2), 32'h0);

    // High inputs held through reset must not be captured after release.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("warmup_irq", 32'(irq), 32'h0);
      check("warmup_ec", readdata, 32'h0);
      check("warmup_ec2", readdata2, 32'h0);
    end
    rd_chk("held_data", 2'd0, 32'h0000_00FF);

    // Bit 3 falls then rises.
    in_port = 8'hF7;
    ticks(4);
    in_port = 8'hFF;
    ticks(4);
    rd_chk("bit3_ec", 2'd3, 32'h0000_0008);
    wr(2'd3, 32'hFF);
    rd_chk("bit3_cleared", 2'd3, 32'h0);

    // Data register latency: change sampled at edge k, readdata valid after k+2.
    in_port = 8'h00;
    ticks(4);
    address = 2'd0;
    tick();
    in_port = 8'hA5;
    tick();
    tick();
    check("lat_k1", readdata, 32'h0);
    tick();
    check("lat_k2", readdata, 32'h0000_00A5);
    tick();
    check("lat_hold", readdata, 32'h0000_00A5);
    in_port = 8'h00;
    ticks(4);

    // Table: mask, input pattern, captured edges and irq.
    for (int i = 0; i < 5; i++) begin
      wr(2'd3, 32'hFF);
      wr(2'd2, 32'(vecs[i].mask));
      in_port = vecs[i].pin;
      ticks(4);
      check("vec_irq", 32'(irq), 32'(vecs[i].irq));
      rd_chk("vec_data", 2'd0, 32'(vecs[i].pin));
      rd_chk("vec_reg1", 2'd1, 32'h0);
      rd_chk("vec_mask", 2'd2, 32'(vecs[i].mask));
      rd_chk("vec_ec", 2'd3, 32'(vecs[i].ec));
    end

    // Writes to addresses 0/1 and unselected writes are ignored.
    wr(2'd0, 32'h0000_0000);
    wr(2'd1, 32'hFFFF_FFFF);
    address   = 2'd2;
    writedata = 32'h0;
    write_n   = 1'b0;
    tick();
    write_n   = 1'b1;
    rd_chk("ign_data", 2'd0, 32'h0000_003C);
    rd_chk("ign_reg1", 2'd1, 32'h0);
    rd_chk("ign_mask", 2'd2, 32'h0000_00C3);

    // Capture timing and irq assertion on the capture cycle.
    in_port = 8'h00;
    ticks(4);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h01);
    check("irq_idle", 32'(irq), 32'h0);
    in_port = 8'h03;
    tick();
    check("irq_k", 32'(irq), 32'h0);
    tick();
    check("irq_k1", 32'(irq), 32'h0);
    tick();
    check("irq_k2", 32'(irq), 32'h1);
    rd_chk("ec_03", 2'd3, 32'h0000_0003);

    // Partial clear and unmask of an already-set bit.
    wr(2'd3, 32'h01);
    check("clr_irq", 32'(irq), 32'h0);
    rd_chk("clr_ec", 2'd3, EXP_EC_PARTIAL);
    wr(2'd2, 32'h02);
    check("unmask_irq", 32'(irq), 32'(EXP_IRQ_UNMASK));

    // Set wins over a same-cycle clear.
    wr(2'd2, 32'h01);
    in_port = 8'h00;
    ticks(4);
    wr(2'd3, 32'hFF);
    in_port = 8'h01;
    ticks(4);
    check("sticky_pre", 32'(irq), 32'h1);
    in_port = 8'h00;
    ticks(4);
    check("sticky_hold", 32'(irq), 32'h1);
    in_port = 8'h01;
    tick();
    tick();
    wr(2'd3, 32'hFF);
    check("setwins_irq", 32'(irq), 32'h1);
    rd_chk("setwins_ec", 2'd3, 32'h0000_0001);
    wr(2'd3, 32'hFF);
    check("plain_clr_irq", 32'(irq), 32'h0);

    // Any-edge instance: falling edge on bit 7.
    in_port2 = 8'h00;
    ticks(4);
    address = 2'd3;
    tick();
    check("any_fall_ec2", readdata2, 32'h0000_0080);

    // Reset mid-toggle clears everything immediately and drops the pending edge.
    in_port2 = 8'h80;
    tick();
    reset = 1'b1;
    #1;
    check("midrst_rd2", readdata2, 32'h0);
    check("midrst_irq2", 32'(irq2), 32'h0);
    check("midrst_rd", readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(10);
    address = 2'd3;
    tick();
    check("postrst_ec2", readdata2, 32'h0);
    check("postrst_ec", readdata, 32'h0);
    rd_chk("postrst_mask", 2'd2, 32'h0);

    // Any-edge detection resumes after warm-up.
    in_port2 = 8'h00;
    ticks(4);
    address = 2'd3;
    tick();
    check("any_fall2_ec2", readdata2, 32'h0000_0080);
    check("any_irq2_masked", 32'(irq2), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vectadd_pio_edge_in.md
VECTADD_PIO_EDGE_IN -- requirements
Module: vectadd_pio_edge_in

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, legal 1..32: width of in_port and all per-bit registers.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: depth of the in_port synchroniser chain.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: edge that sets a capture bit (0 rising, 1 falling, 2 any).
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports below, clock and reset first.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select; qualifies writes only.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data; only bits [DATA_WIDTH-1:0] used.
REQ-011 in_port  input  DATA_WIDTH  asynchronous external input bits.
REQ-012 readdata  output  32  registered read data, bits above DATA_WIDTH zero.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 Register map SHALL be: 0 data (RO), 1 reads 0/writes ignored, 2 irq_mask (RW), 3 edge_capture (RO, write clears).
REQ-015 in_port SHALL pass through a SYNC_STAGES-deep flop chain; data register = chain output.
REQ-016 readdata SHALL be loaded every clock from the register selected by address; 1-cycle read latency; chipselect not required.
REQ-017 A write SHALL occur when chipselect=1 and write_n=0; irq_mask <= writedata[DATA_WIDTH-1:0] on write to address 2.
REQ-018 A prev register SHALL hold the previous chain output; edge on bit i per EDGE_TYPE comparing chain output vs prev.
REQ-019 in_port change sampled at edge k SHALL set edge_capture[i] at edge k+SYNC_STAGES.
REQ-020 edge_capture bits SHALL be sticky until cleared by write (see Configuration).
REQ-021 Same-cycle edge detection and clear on a bit: set SHALL win; bit remains 1.
REQ-022 irq SHALL be combinational |(edge_capture & irq_mask), asserting the cycle edge_capture bit is set if unmasked.
REQ-023 Masking SHALL not affect capture; unmasking an already-set bit asserts irq immediately.
REQ-024 A warm-up counter SHALL suppress edge detection for SYNC_STAGES+1 clocks after reset release; prev tracks chain output during warm-up.
REQ-025 Writes to addresses 0 and 1 SHALL have no effect.

Reset
REQ-026 reset SHALL asynchronously clear synchroniser chain, prev, irq_mask, edge_capture, readdata and warm-up counter to 0.
REQ-027 irq SHALL be 0 during and immediately after reset.
REQ-028 Reset asserted mid-operation SHALL discard pending edges and restart warm-up on release.
REQ-029 A high in_port held through reset SHALL NOT set any capture bit after release.

Configuration
REQ-030 Macro VECTADD_PIO_BIT_CLEAR_EN defined: write to address 3 clears only bits where writedata=1 (write-1-to-clear).
REQ-031 Macro VECTADD_PIO_BIT_CLEAR_EN undefined: any write to address 3 clears all edge_capture bits regardless of writedata.

Verification (DATA_WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0 unless stated)
REQ-032 in_port=8'hA5 held 4 clocks, address=0 -> readdata=32'h000000A5, appears 3 clocks after in_port change.
REQ-033 irq_mask=8'h01, in_port 0->8'h03 -> edge_capture=8'h03 at edge k+2, irq=1 same cycle; read address 3 returns 32'h03.
REQ-034 With BIT_CLEAR_EN: write 8'h01 to address 3 -> edge_capture=8'h02, irq=0; without macro: edge_capture=8'h00.
REQ-035 Rising edge on bit 0 in same cycle as clearing write -> edge_capture[0] stays 1, irq stays 1.
REQ-036 in_port=8'hFF held through reset, release -> edge_capture=0, irq=0 for 10 clocks; then bit 3 falls and rises -> edge_capture=8'h08.
REQ-037 EDGE_TYPE=2, in_port bit 7 toggles 1->0 -> edge_capture=8'h80; reset mid-toggle -> all registers 0 immediately.
